prio_encoder_q: RTL and testbench
=================================

# prio_encoder_q

Parametrised, registered N-to-log2(N) priority encoder with request capture and a valid/ready output. Generalises the 4-to-2 encoder: it supports any width and a selectable priority direction, and it captures one-cycle request pulses so none are lost. Each pending request is emitted exactly once, as a binary index, in priority order. It sits between interrupt or event sources and a single consumer that services one event per accepted transfer.

## Interface
Parameters:
- N, 8: number of request lines, 2..64.
- W, $clog2(N): index width, derived, not overridden.
- MSB_FIRST, 1: 1 = highest index has highest priority (4-to-2 behaviour: input 3 encodes to 2'b11 and wins); 0 = lowest index wins.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i  input  N  request lines, level-sampled every cycle; a 1-cycle pulse suffices.
- flush_i  input  1  synchronous clear of all pending state.
- out_valid_o  output  1  out_idx_o / out_onehot_o hold a valid selection.
- out_ready_i  input  1  consumer accepts when out_valid_o && out_ready_i.
- out_idx_o  output  W  binary index of selected request.
- out_onehot_o  output  N  one-hot of out_idx_o.
- pending_o  output  N  registered pending mask, including the presented bit.
- dup_o  output  1  sticky: a request arrived on a bit already pending and not being cleared that cycle.

## Operation
- State: pending[N-1:0], output register (valid, idx, onehot), dup flag.
- acc = out_valid_o && out_ready_i; clr = acc ? out_onehot_o : 0.
- Pending update: pending <= (pending & ~clr) | req_i.
- Load condition ld = !out_valid_o || out_ready_i.
- On ld:
  - cand = pending & ~clr.
  - If cand != 0: out_valid_o <= 1, and idx/onehot <= the priority winner of cand (MSB_FIRST selects the highest set bit, otherwise the lowest).
  - If cand == 0: out_valid_o <= 0, and idx/onehot <= 0.
- When !ld (stalled), the output register holds every field unchanged.
- The presented bit stays set in pending until accepted. A bit is never presented twice per request.
- Re-request in the same cycle as acceptance of the same bit: the bit stays pending and is presented again later.
- dup_o <= dup_o | |(req_i & pending & ~clr). It is cleared only by rst or flush_i.
- flush_i: pending <= 0, out_valid_o <= 0, idx/onehot <= 0, dup_o <= 0.
- flush_i has priority over req_i and acceptance in the same cycle: requests in the flush cycle are dropped.
- rst has priority over flush_i.

## Timing
- Reset values:
  - out_valid_o = 0
  - out_idx_o = 0
  - out_onehot_o = 0
  - pending_o = 0
  - dup_o = 0
- Latency: req_i high in cycle 0 gives pending set in cycle 1 and out_valid_o in cycle 2, provided the output register is idle or accepting.
- Throughput: one accepted index per cycle with out_ready_i held high and at least 2 bits pending.
- Backpressure: while out_valid_o && !out_ready_i, all out_* are stable. A higher-priority request arriving during a stall does not pre-empt the held selection; it wins the next load.
- Priority is evaluated on pending at load time, not at request-arrival time.
- Wrap/overflow: none. Capacity is one outstanding event per line, and extra requests on a pending line are merged and flagged by dup_o.
- Reset or flush mid-transfer: the presented item is discarded and not re-presented.
- No combinational path from req_i or out_ready_i to any output.

## Test plan
- Reset: assert rst 2 cycles with req_i = 8'hFF → all outputs 0. After release, no out_valid_o until cycle 2 of requests.
- Single pulse: N=8, MSB_FIRST=1, req_i = 8'h10 for 1 cycle, ready high → out_valid_o exactly 1 cycle, 2 cycles later, with out_idx_o = 4 and out_onehot_o = 8'h10. pending_o returns to 0.
- Priority order: req_i = 8'b1000_1001 pulse, ready high → indices 7, 3, 0 on consecutive cycles. With MSB_FIRST=0 → 0, 3, 7.
- Backpressure: pending 8'h06, ready low 5 cycles → out_idx_o = 2 stable throughout. Inject req_i = 8'h80 during the stall → order after release is 2, 7, 1.
- Re-request on accept: bit 5 presented, req_i = 8'h20 in the accept cycle → bit 5 presented again later, and dup_o stays 0. req_i = 8'h20 while bit 5 is pending and not accepted → dup_o = 1.
- Flush: 3 bits pending, out_valid_o = 1, flush_i with req_i = 8'h01 in the same cycle → next cycle all outputs 0 and dup_o = 0. No output appears afterwards.

Source files
------------

// File: rtl/prio_encoder_q.sv
// rtl/prio_encoder_q.sv - registered N-to-log2(N) priority encoder with request capture and valid/ready output
module prio_encoder_q #(
  parameter int N         = 8,
  parameter int W         = $clog2(N),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         flush_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_idx_o,
  output logic [N-1:0] out_onehot_o,
  output logic [N-1:0] pending_o,
  output logic         dup_o
);

  logic [N-1:0] pending;
  logic         acc;
  logic         ld;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [W-1:0] win_idx;
  logic [N-1:0] win_oh;

  assign acc  = out_valid_o && out_ready_i;
  assign clr  = acc ? out_onehot_o : '0;
  assign ld   = !out_valid_o || out_ready_i;
  // The bit being accepted this cycle must not be re-selected on the same load.
  assign cand = pending & ~clr;

  assign pending_o = pending;

  // Priority winner of the candidates; the last match in scan order wins.
  always_comb begin
    win_idx = '0;
    win_oh  = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) win_idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (cand[i]) win_idx = W'(i);
      end
    end
    if (cand != '0) win_oh[win_idx] = 1'b1;
  end

  // Pending capture, output register load/hold, sticky duplicate flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      out_valid_o  <= 1'b0;
      out_idx_o    <= '0;
      out_onehot_o <= '0;
      dup_o        <= 1'b0;
    end else if (flush_i) begin
      pending      <= '0;
      out_valid_o  <= 1'b0;
      out_idx_o    <= '0;
      out_onehot_o <= '0;
      dup_o        <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | req_i;
      dup_o   <= dup_o | (|(req_i & pending & ~clr));
      if (ld) begin
        out_valid_o  <= (cand != '0);
        out_idx_o    <= win_idx;
        out_onehot_o <= win_oh;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_q.sv
// tb/tb_prio_encoder_q.sv - self-checking bench for prio_encoder_q, MSB-first and LSB-first instances
module tb_prio_encoder_q;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       flush = 1'b0;
  logic       ready = 1'b1;

  logic       valid_m, valid_l;
  logic [2:0] idx_m, idx_l;
  logic [7:0] oh_m, oh_l;
  logic [7:0] pend_m, pend_l;
  logic       dup_m, dup_l;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_seen = 0;
  int first_cyc = 0;
  int last_cyc = 0;

  logic [2:0] q_m[$];
  logic [2:0] q_l[$];

  // Sequences are packed 3 bits per item, item 0 in the least significant
  // octal digit, so 24'o037 means 7 then 3 then 0.
  typedef struct {
    logic [7:0]  req;
    int          cnt;
    logic [23:0] m_seq;
    logic [23:0] l_seq;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prio_encoder_q #(.N(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .req_i(req), .flush_i(flush),
    .out_valid_o(valid_m), .out_ready_i(ready), .out_idx_o(idx_m),
    .out_onehot_o(oh_m), .pending_o(pend_m), .dup_o(dup_m)
  );

  prio_encoder_q #(.N(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .req_i(req), .flush_i(flush),
    .out_valid_o(valid_l), .out_ready_i(ready), .out_idx_o(idx_l),
    .out_onehot_o(oh_l), .pending_o(pend_l), .dup_o(dup_l)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input logic [2:0] m, input logic [2:0] l);
    q_m.push_back(m);
    q_l.push_back(l);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q_m.size() != 0 || q_l.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left_m", 64'(q_m.size()), 64'd0);
    chk("drain_left_l", 64'(q_l.size()), 64'd0);
    q_m.delete();
    q_l.delete();
  endtask

  task automatic chk_idle(input string name);
    @(negedge clk);
    chk({name, "_valid_m"}, {63'd0, valid_m}, 64'd0);
    chk({name, "_valid_l"}, {63'd0, valid_l}, 64'd0);
    chk({name, "_pend_m"}, {56'd0, pend_m}, 64'd0);
    chk({name, "_pend_l"}, {56'd0, pend_l}, 64'd0);
  endtask

  // Scoreboard: every accepted transfer must match the head of its queue.
  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst && ready) begin
      if (valid_m) begin
        if (q_m.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_m: got idx %0d expected no output (t=%0t)", idx_m, $time);
        end else begin
          e = q_m.pop_front();
          chk("idx_m", {61'd0, idx_m}, {61'd0, e});
          chk("onehot_m", {56'd0, oh_m}, {56'd0, 8'd1 << e});
          if (acc_seen == 0) first_cyc = cyc;
          last_cyc = cyc;
          acc_seen++;
        end
      end
      if (valid_l) begin
        if (q_l.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_l: got idx %0d expected no output (t=%0t)", idx_l, $time);
        end else begin
          e = q_l.pop_front();
          chk("idx_l", {61'd0, idx_l}, {61'd0, e});
          chk("onehot_l", {56'd0, oh_l}, {56'd0, 8'd1 << e});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{req: 8'h10, cnt: 1, m_seq: 24'o4,        l_seq: 24'o4};
    vecs[1] = '{req: 8'h89, cnt: 3, m_seq: 24'o037,      l_seq: 24'o730};
    vecs[2] = '{req: 8'h06, cnt: 2, m_seq: 24'o12,       l_seq: 24'o21};
    vecs[3] = '{req: 8'hFF, cnt: 8, m_seq: 24'o01234567, l_seq: 24'o76543210};
    vecs[4] = '{req: 8'h01, cnt: 1, m_seq: 24'o0,        l_seq: 24'o0};
    vecs[5] = '{req: 8'h81, cnt: 2, m_seq: 24'o07,       l_seq: 24'o70};

    // Reset held two cycles with every request line high.
    rst = 1'b1; req = 8'hFF; ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_valid", {62'd0, valid_m, valid_l}, 64'd0);
      chk("rst_idx", {58'd0, idx_m, idx_l}, 64'd0);
      chk("rst_onehot", {48'd0, oh_m, oh_l}, 64'd0);
      chk("rst_pend", {48'd0, pend_m, pend_l}, 64'd0);
      chk("rst_dup", {62'd0, dup_m, dup_l}, 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; req = 8'h00;
    tick();

    // Single pulse: pending after one cycle, valid after two, for one cycle.
    push_both(3'd4, 3'd4);
    req = 8'h10;
    tick();
    req = 8'h00;
    @(negedge clk);
    chk("pulse_valid_c1", {63'd0, valid_m}, 64'd0);
    chk("pulse_pend_c1", {56'd0, pend_m}, 64'h10);
    tick();
    @(negedge clk);
    chk("pulse_valid_c2", {63'd0, valid_m}, 64'd1);
    tick();
    @(negedge clk);
    chk("pulse_valid_c3", {63'd0, valid_m}, 64'd0);
    chk("pulse_pend_c3", {56'd0, pend_m}, 64'd0);
    drain(5);

    // Table: one-cycle request pattern, ready high, ordered drain.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].cnt; k++)
        push_both(vecs[v].m_seq[3*k +: 3], vecs[v].l_seq[3*k +: 3]);
      acc_seen = 0;
      ready = 1'b1;
      req = vecs[v].req;
      tick();
      req = 8'h00;
      drain(30);
      chk("burst_span", 64'(last_cyc - first_cyc), 64'(vecs[v].cnt - 1));
      tick();
      chk_idle("after_vec");
    end

    // Backpressure: held selection is stable, late high-priority request waits.
    push_both(3'd2, 3'd1);
    push_both(3'd7, 3'd2);
    push_both(3'd1, 3'd7);
    ready = 1'b0;
    req = 8'h06;
    tick();
    req = 8'h00;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, valid_m}, 64'd1);
      chk("stall_idx_m", {61'd0, idx_m}, 64'd2);
      chk("stall_idx_l", {61'd0, idx_l}, 64'd1);
      @(posedge clk); #1;
      req = (k == 1) ? 8'h80 : 8'h00;
    end
    ready = 1'b1;
    drain(20);
    tick();
    chk_idle("after_stall");

    // Re-request in the accept cycle: presented twice, no duplicate flag.
    push_both(3'd5, 3'd5);
    push_both(3'd5, 3'd5);
    req = 8'h20;
    tick();
    req = 8'h00;
    tick();
    req = 8'h20;
    tick();
    req = 8'h00;
    drain(20);
    chk("rereq_dup", {62'd0, dup_m, dup_l}, 64'd0);
    tick();
    chk_idle("after_rereq");

    // Request on a pending, unaccepted bit sets the sticky flag.
    ready = 1'b0;
    req = 8'h20;
    tick();
    req = 8'h00;
    tick();
    @(negedge clk);
    chk("dup_before", {62'd0, dup_m, dup_l}, 64'd0);
    @(posedge clk); #1;
    req = 8'h20;
    tick();
    req = 8'h00;
    @(negedge clk);
    chk("dup_set", {62'd0, dup_m, dup_l}, 64'h3);
    push_both(3'd5, 3'd5);
    ready = 1'b1;
    drain(20);
    chk("dup_sticky", {62'd0, dup_m, dup_l}, 64'h3);

    // Flush with a simultaneous request drops everything.
    ready = 1'b0;
    req = 8'h0E;
    tick();
    req = 8'h00;
    tick();
    @(negedge clk);
    chk("preflush_valid", {62'd0, valid_m, valid_l}, 64'h3);
    chk("preflush_pend", {56'd0, pend_m}, 64'h0E);
    @(posedge clk); #1;
    flush = 1'b1;
    req = 8'h01;
    tick();
    flush = 1'b0;
    req = 8'h00;
    @(negedge clk);
    chk("flush_valid", {62'd0, valid_m, valid_l}, 64'd0);
    chk("flush_idx", {58'd0, idx_m, idx_l}, 64'd0);
    chk("flush_onehot", {48'd0, oh_m, oh_l}, 64'd0);
    chk("flush_pend", {48'd0, pend_m, pend_l}, 64'd0);
    chk("flush_dup", {62'd0, dup_m, dup_l}, 64'd0);
    ready = 1'b1;
    repeat (6) tick();
    chk_idle("after_flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
